// File: rtl/mtr_drv_pwm_pkg.sv
// Shared types and helpers for the motor-drive PWM stage.
package mtr_drv_pkg;
  localparam int PWM_W = 11;
  typedef logic [PWM_W-1:0] duty_t;
  typedef logic signed [11:0] spd_t;

  localparam duty_t DUTY_ZERO = 11'h400;
  localparam duty_t CNT_TOP   = 11'h7FF;

  // Offset-binary map: -2048 -> 0, 0 -> 0x400, 2047 -> 0x7FF (LSB of speed is dropped).
  function automatic duty_t spd2duty(input spd_t spd);
    return duty_t'({~spd[11], spd[10:0]} >> 1);
  endfunction
endpackage

// File: rtl/mtr_drv_pwm_if.sv
// Speed command / over-current inputs and gate-drive outputs of the motor-drive stage.
interface mtr_drv_pwm_if;
  import mtr_drv_pkg::*;

  spd_t lft_spd;
  spd_t rght_spd;
  logic ovr_i;
  logic PWM1_lft;
  logic PWM2_lft;
  logic PWM1_rght;
  logic PWM2_rght;
  logic pwm_synch;
  logic ovr_i_shtdwn;

  modport master (
    output lft_spd, rght_spd, ovr_i,
    input  PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, pwm_synch, ovr_i_shtdwn
  );

  modport slave (
    input  lft_spd, rght_spd, ovr_i,
    output PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, pwm_synch, ovr_i_shtdwn
  );
endinterface

// File: rtl/mtr_drv_pwm_nonoverlap.sv
// One half-bridge: raw PWM compare result -> complementary gate pair with dead time,
// plus a blanking counter that reports when the high side has been on long enough to trust ovr_i.
module pwm_nonoverlap #(
  parameter logic [5:0] NONOVERLAP = 6'd32,
  parameter logic [7:0] BLANK      = 8'd128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_sig_next,
  input  logic kill,
  output logic pwm1,
  output logic pwm2,
  output logic blank_done
);
  logic [5:0] hi_run_reg;
  logic [5:0] lo_run_reg;
  logic [7:0] blank_reg;
  logic       pwm1_next;
  logic       pwm2_next;

  // Run counters hold how many consecutive clks the registered PWM_sig has sat at each level.
  assign pwm1_next = pwm_sig_next && (hi_run_reg >= NONOVERLAP) && !kill;
  assign pwm2_next = !pwm_sig_next && (lo_run_reg >= NONOVERLAP) && !kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_run_reg <= '0;
      lo_run_reg <= '0;
      blank_reg  <= '0;
      pwm1       <= 1'b0;
      pwm2       <= 1'b0;
    end else begin
      if (!pwm_sig_next)
        hi_run_reg <= '0;
      else if (hi_run_reg < NONOVERLAP)
        hi_run_reg <= hi_run_reg + 6'd1;

      if (pwm_sig_next)
        lo_run_reg <= '0;
      else if (lo_run_reg < NONOVERLAP)
        lo_run_reg <= lo_run_reg + 6'd1;

      if (pwm1_next && !pwm1)
        blank_reg <= '0;
      else if (blank_reg != BLANK)
        blank_reg <= blank_reg + 8'd1;

      pwm1 <= pwm1_next;
      pwm2 <= pwm2_next;
    end
  end

  assign blank_done = pwm1 && (blank_reg == BLANK);
endmodule

// File: rtl/mtr_drv_pwm.sv
// Motor-drive stage: wheel speed commands -> dead-time protected H-bridge gate pairs,
// with blanked over-current detection and a sticky shutdown that coasts both motors.
module mtr_drv_pwm
  import mtr_drv_pkg::*;
#(
  parameter logic [5:0] NONOVERLAP = 6'd32,
  parameter logic [7:0] BLANK      = 8'd128,
  parameter logic [4:0] OVR_LIMIT  = 5'd20
) (
  input logic          clk,
  input logic          rst_n,
  mtr_drv_pwm_if.slave bus
);
  localparam int NCH = 2;  // channel 0 = left wheel, 1 = right wheel

  duty_t          cnt_reg;
  spd_t           spd [NCH];
  logic [NCH-1:0] pwm1;
  logic [NCH-1:0] pwm2;
  logic [NCH-1:0] blank_done;
  logic           pwm_synch;
  logic           ovr_meta_reg;
  logic           ovr_sync_reg;
  logic           ovr_flag_reg;
  logic [4:0]     ovr_cnt_reg;
  logic           shtdwn_reg;
  logic           ovr_qual;
  logic           ovr_trip;
  logic           kill;

  assign spd[0]    = bus.lft_spd;
  assign spd[1]    = bus.rght_spd;
  assign pwm_synch = (cnt_reg == CNT_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + duty_t'(1);
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      duty_t duty_reg;

      // Duty only changes at the period boundary so a pulse is never cut short mid-period.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          duty_reg <= DUTY_ZERO;
        else if (pwm_synch)
          duty_reg <= spd2duty(spd[gi]);
      end

      pwm_nonoverlap #(
        .NONOVERLAP (NONOVERLAP),
        .BLANK      (BLANK)
      ) u_nov (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_sig_next (cnt_reg < duty_reg),
        .kill         (kill),
        .pwm1         (pwm1[gi]),
        .pwm2         (pwm2[gi]),
        .blank_done   (blank_done[gi])
      );
    end
  endgenerate

  assign ovr_qual = ovr_sync_reg && (|blank_done);
  assign ovr_trip = (ovr_cnt_reg == OVR_LIMIT);
  // Gates are dropped on the same edge the shutdown flag rises, not one clk later.
  assign kill     = shtdwn_reg || ovr_trip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_meta_reg <= 1'b0;
      ovr_sync_reg <= 1'b0;
      ovr_flag_reg <= 1'b0;
      ovr_cnt_reg  <= '0;
      shtdwn_reg   <= 1'b0;
    end else begin
      ovr_meta_reg <= bus.ovr_i;
      ovr_sync_reg <= ovr_meta_reg;

      if (pwm_synch) begin
        ovr_flag_reg <= 1'b0;
        if (ovr_flag_reg || ovr_qual) begin
          if (!ovr_trip)
            ovr_cnt_reg <= ovr_cnt_reg + 5'd1;
        end else begin
          ovr_cnt_reg <= '0;
        end
      end else if (ovr_qual) begin
        ovr_flag_reg <= 1'b1;
      end

      if (ovr_trip)
        shtdwn_reg <= 1'b1;
    end
  end

  assign bus.PWM1_lft     = pwm1[0];
  assign bus.PWM2_lft     = pwm2[0];
  assign bus.PWM1_rght    = pwm1[1];
  assign bus.PWM2_rght    = pwm2[1];
  assign bus.pwm_synch    = pwm_synch;
  assign bus.ovr_i_shtdwn = shtdwn_reg;
endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Scoreboard bench for mtr_drv_pwm: per-period gate widths, overlap, period length and shutdown
// are checked by a monitor at every pwm_synch against entries queued by the stimulus.
module tb_mtr_drv_pwm;
  import mtr_drv_pkg::*;

  localparam logic [4:0] TB_OVR_LIMIT = 5'd5;

  typedef struct {
    bit chk;
    int p1l, p2l, p1r, p2r;
    bit sd;
  } exp_t;

  typedef struct {
    spd_t l, r;
    int   p1l, p2l, p1r, p2r;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   per_idx = 0;
  exp_t sb_q[$];
  vec_t vtab [0:5];

  always #5 clk = ~clk;

  mtr_drv_pwm_if bus ();

  mtr_drv_pwm #(.OVR_LIMIT(TB_OVR_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input bit chk, input int a, input int b, input int c, input int d,
                          input bit sd);
    exp_t e;
    e.chk = chk; e.p1l = a; e.p2l = b; e.p1r = c; e.p2r = d; e.sd = sd;
    sb_q.push_back(e);
  endtask

  task automatic push_vec(input vec_t v);
    push_exp(1'b1, v.p1l, v.p2l, v.p1r, v.p2r, 1'b0);
  endtask

  task automatic wait_synch();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pwm_synch && n < 4096);
    if (!bus.pwm_synch) check("synch_timeout", 0, 1);
  endtask

  // One period with an ovr_i pulse placed dly clks after PWM1_lft rises.
  task automatic ovr_period(input int dly, input vec_t v);
    int n = 0;
    push_vec(v);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.PWM1_lft && n < 4096);
    if (!bus.PWM1_lft) check("pwm1_rise_timeout", 0, 1);
    repeat (dly) @(negedge clk);
    bus.ovr_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.ovr_i = 1'b0;
    wait_synch();
  endtask

  // Monitor: accumulates one period of outputs and compares when pwm_synch marks its end.
  initial begin
    int len, c1l, c2l, c1r, c2r, ovl;
    exp_t e;
    len = 0; c1l = 0; c2l = 0; c1r = 0; c2r = 0; ovl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        len = 0; c1l = 0; c2l = 0; c1r = 0; c2r = 0; ovl = 0;
      end else begin
        len++;
        c1l += int'(bus.PWM1_lft);
        c2l += int'(bus.PWM2_lft);
        c1r += int'(bus.PWM1_rght);
        c2r += int'(bus.PWM2_rght);
        if ((bus.PWM1_lft && bus.PWM2_lft) || (bus.PWM1_rght && bus.PWM2_rght)) ovl++;
        if (bus.pwm_synch) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 0, 1);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("p%0d_overlap", per_idx), ovl, 0);
            check($sformatf("p%0d_shtdwn", per_idx), int'(bus.ovr_i_shtdwn), int'(e.sd));
            if (e.chk) begin
              check($sformatf("p%0d_len", per_idx), len, 2048);
              check($sformatf("p%0d_pwm1_lft", per_idx), c1l, e.p1l);
              check($sformatf("p%0d_pwm2_lft", per_idx), c2l, e.p2l);
              check($sformatf("p%0d_pwm1_rght", per_idx), c1r, e.p1r);
              check($sformatf("p%0d_pwm2_rght", per_idx), c2r, e.p2r);
            end
            $display("period %0d len=%0d pwm=%0d/%0d/%0d/%0d shtdwn=%0b", per_idx, len,
                     c1l, c2l, c1r, c2r, bus.ovr_i_shtdwn);
          end
          per_idx++;
          len = 0; c1l = 0; c2l = 0; c1r = 0; c2r = 0; ovl = 0;
        end
      end
    end
  end

  initial begin
    // Hand-computed steady widths: duty D -> PWM1 = max(0, D-32), PWM2 = max(0, 2048-D-32).
    vtab[0] = '{12'h000, 12'h000,  992,  992,  992,  992};  // 0x400 / 0x400
    vtab[1] = '{12'h7FF, 12'h800, 2015,    0,    0, 2048};  // 0x7FF / 0 (low side never ends)
    vtab[2] = '{12'h100, 12'hF00, 1120,  864,  864, 1120};  // 0x480 / 0x380
    vtab[3] = '{12'h040, 12'h842, 1024,  960,    1, 1983};  // 0x420 / 33
    vtab[4] = '{12'h83F, 12'h7C0,    0, 1985, 1984,    0};  // 31 / 2016
    vtab[5] = '{12'h840, 12'h7BE,    0, 1984, 1983,    1};  // 32 / 2015

    bus.lft_spd  = '0;
    bus.rght_spd = '0;
    bus.ovr_i    = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_pwm1_lft", int'(bus.PWM1_lft), 0);
    check("rst_pwm2_lft", int'(bus.PWM2_lft), 0);
    check("rst_pwm1_rght", int'(bus.PWM1_rght), 0);
    check("rst_pwm2_rght", int'(bus.PWM2_rght), 0);
    check("rst_synch", int'(bus.pwm_synch), 0);
    check("rst_shtdwn", int'(bus.ovr_i_shtdwn), 0);
    @(negedge clk);
    rst_n = 1'b1;

    push_exp(1'b0, 0, 0, 0, 0, 1'b0);
    wait_synch();

    // Each new command lands at cnt~500; the running period must keep the old widths.
    for (int i = 1; i < 6; i++) begin
      push_vec(vtab[i-1]);
      repeat (500) @(negedge clk);
      bus.lft_spd  = vtab[i].l;
      bus.rght_spd = vtab[i].r;
      wait_synch();
      push_exp(1'b0, 0, 0, 0, 0, 1'b0);
      wait_synch();
    end

    for (int r = 0; r < 4; r++) begin
      if (r == 0) push_vec(vtab[5]);
      else push_exp(1'b0, 0, 0, 0, 0, 1'b0);
      repeat ($urandom_range(1, 2000)) @(negedge clk);
      bus.lft_spd  = spd_t'($urandom_range(0, 4095));
      bus.rght_spd = spd_t'($urandom_range(0, 4095));
      wait_synch();
    end
    push_exp(1'b0, 0, 0, 0, 0, 1'b0);
    repeat (500) @(negedge clk);
    bus.lft_spd  = '0;
    bus.rght_spd = '0;
    wait_synch();
    push_exp(1'b0, 0, 0, 0, 0, 1'b0);
    wait_synch();

    // Over-current: blanked pulse ignored, LIMIT-1 hits then a clean period, then LIMIT hits.
    ovr_period(50, vtab[0]);
    for (int k = 0; k < int'(TB_OVR_LIMIT) - 1; k++) ovr_period(200, vtab[0]);
    push_vec(vtab[0]);
    wait_synch();
    for (int k = 0; k < int'(TB_OVR_LIMIT); k++) ovr_period(200, vtab[0]);
    push_exp(1'b0, 0, 0, 0, 0, 1'b1);
    wait_synch();
    push_exp(1'b1, 0, 0, 0, 0, 1'b1);
    wait_synch();

    // Asynchronous reset mid-period while shut down.
    repeat (700) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_shtdwn", int'(bus.ovr_i_shtdwn), 0);
    check("arst_pwm1_lft", int'(bus.PWM1_lft), 0);
    check("arst_pwm2_rght", int'(bus.PWM2_rght), 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b0, 0, 0, 0, 0, 1'b0);
    wait_synch();
    push_vec(vtab[0]);
    wait_synch();

    repeat (5) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
